// File: rtl/axil_pwm_regslave.sv
// AXI4-Lite slave with four R/W registers (CTRL, PERIOD, DUTY, SCRATCH) driving one PWM output.
// PWM settings are shadowed and take effect at a period boundary, so the output never glitches.
module axil_pwm_regslave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic                              pwm_out
);

    localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned NREG = 4;
    localparam int unsigned IW   = 2;

    typedef struct packed {
        logic          en;
        logic          inv;
        logic [DW-1:0] period;
        logic [DW-1:0] duty;
    } pwm_cfg_t;

    logic [DW-1:0] regs [NREG];

    logic          aw_full, aw_full_n;
    logic [IW-1:0] aw_idx, aw_idx_n;
    logic          w_full, w_full_n;
    logic [DW-1:0] w_data, w_data_n;
    logic [SW-1:0] w_strb, w_strb_n;
    logic          awready, awready_n;
    logic          wready, wready_n;
    logic          bvalid, bvalid_n;
    logic          arready, arready_n;
    logic          rvalid, rvalid_n;
    logic [DW-1:0] rdata, rdata_n;

    logic [DW-1:0] cnt, cnt_n;
    pwm_cfg_t      shadow, shadow_n;
    logic          pwm_q, pwm_n;

    logic          aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
    logic          do_write_c, wrap_c;
    logic [DW-1:0] wr_word_c;

    logic          unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

    assign s00_axi_awready = awready;
    assign s00_axi_wready  = wready;
    assign s00_axi_bvalid  = bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready;
    assign s00_axi_rvalid  = rvalid;
    assign s00_axi_rdata   = rdata;
    assign s00_axi_rresp   = 2'b00;
    assign pwm_out         = pwm_q;

    // Next-state for both AXI channels and the PWM engine
    always_comb begin
        aw_full_n = aw_full;
        aw_idx_n  = aw_idx;
        w_full_n  = w_full;
        w_data_n  = w_data;
        w_strb_n  = w_strb;
        bvalid_n  = bvalid;
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        cnt_n     = cnt + DW'(1);
        shadow_n  = shadow;

        aw_hs_c    = s00_axi_awvalid & awready;
        w_hs_c     = s00_axi_wvalid & wready;
        b_hs_c     = bvalid & s00_axi_bready;
        ar_hs_c    = s00_axi_arvalid & arready;
        r_hs_c     = rvalid & s00_axi_rready;
        do_write_c = aw_full & w_full;

        wr_word_c = regs[aw_idx];
        for (int b = 0; b < SW; b++) begin
            if (w_strb[b]) wr_word_c[b*8 +: 8] = w_data[b*8 +: 8];
        end

        if (aw_hs_c) begin
            aw_full_n = 1'b1;
            aw_idx_n  = s00_axi_awaddr[3:2];
        end else if (do_write_c) begin
            aw_full_n = 1'b0;
        end

        if (w_hs_c) begin
            w_full_n = 1'b1;
            w_data_n = s00_axi_wdata;
            w_strb_n = s00_axi_wstrb;
        end else if (do_write_c) begin
            w_full_n = 1'b0;
        end

        if (do_write_c)  bvalid_n = 1'b1;
        else if (b_hs_c) bvalid_n = 1'b0;

        // Ready only when the channel's holding slot is empty and no response is pending
        awready_n = ~aw_full_n & ~bvalid_n;
        wready_n  = ~w_full_n & ~bvalid_n;

        if (ar_hs_c) begin
            rvalid_n = 1'b1;
            rdata_n  = regs[s00_axi_araddr[3:2]];
        end else if (r_hs_c) begin
            rvalid_n = 1'b0;
        end
        arready_n = ~rvalid_n;

        // Disabled counts as a permanent wrap: cnt parks at 0 and shadows track the registers
        wrap_c = ~shadow.en | (cnt >= shadow.period);
        if (wrap_c) begin
            cnt_n           = '0;
            shadow_n.en     = regs[0][0];
            shadow_n.inv    = regs[0][1];
            shadow_n.period = regs[1];
            shadow_n.duty   = regs[2];
        end
        pwm_n = shadow.en ? ((cnt < shadow.duty) ^ shadow.inv) : shadow.inv;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_full <= 1'b0;
            aw_idx  <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            cnt     <= '0;
            shadow  <= '0;
            pwm_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            aw_full <= aw_full_n;
            aw_idx  <= aw_idx_n;
            w_full  <= w_full_n;
            w_data  <= w_data_n;
            w_strb  <= w_strb_n;
            awready <= awready_n;
            wready  <= wready_n;
            bvalid  <= bvalid_n;
            arready <= arready_n;
            rvalid  <= rvalid_n;
            rdata   <= rdata_n;
            cnt     <= cnt_n;
            shadow  <= shadow_n;
            pwm_q   <= pwm_n;
            if (do_write_c) regs[aw_idx] <= wr_word_c;
        end
    end

endmodule

// File: tb/tb_axil_pwm_regslave.sv
// Directed bench for axil_pwm_regslave: table of register accesses plus hand-written
// handshake, ordering, PWM shadowing and reset sequences.
module tb_axil_pwm_regslave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        pwm_out;

    int checks = 0;
    int errors = 0;
    int b_cnt  = 0;

    logic mon_prev = 1'b0;
    int   mon_run  = 0;
    int   hi_runs[$];
    int   lo_runs[$];

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    axil_pwm_regslave dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .pwm_out         (pwm_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bvalid && bready) b_cnt++;
    end

    // Run-length log of pwm_out, sampled mid-cycle
    always @(negedge clk) begin
        if (pwm_out == mon_prev) begin
            mon_run++;
        end else begin
            if (mon_prev) hi_runs.push_back(mon_run);
            else          lo_runs.push_back(mon_run);
            mon_prev = pwm_out;
            mon_run  = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for handshake", name);
    endtask

    task automatic aw_send(input logic [3:0] a);
        bit ok = 1'b0;
        awaddr  = a;
        awvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (awready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) @(negedge clk);
        else    timeout("aw_handshake");
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s);
        bit ok = 1'b0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (wready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) @(negedge clk);
        else    timeout("w_handshake");
        wvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] a);
        bit ok = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (arready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) @(negedge clk);
        else    timeout("ar_handshake");
        arvalid = 1'b0;
    endtask

    task automatic b_wait();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bvalid) ok = 1'b1;
            else        @(negedge clk);
        end
        if (!ok) begin
            timeout("bvalid_wait");
        end else begin
            chk("bresp", 32'(bresp), 32'h0);
            if (bready) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    // mode 0: AW and W together, 1: AW two cycles before W, 2: W two cycles before AW
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode);
        fork
            begin
                if (mode == 2) repeat (2) @(negedge clk);
                aw_send(a);
            end
            begin
                if (mode == 1) repeat (2) @(negedge clk);
                w_send(d, s);
            end
        join
        b_wait();
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        ar_send(a);
        chk({name, "_latency"}, 32'(rvalid), 32'h1);
        if (rvalid) begin
            chk(name, rdata, exp);
            chk({name, "_rresp"}, 32'(rresp), 32'h0);
            if (rready) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out) c++;
        end
    endtask

    int          c, h_idx, l_idx, b0, l0;
    bit          seen;

    initial begin
        vecs[0]  = '{1'b1, 4'h0, 32'h1,        4'hF, 0, 32'h0};
        vecs[1]  = '{1'b1, 4'h4, 32'h2,        4'hF, 1, 32'h0};
        vecs[2]  = '{1'b1, 4'h8, 32'h3,        4'hF, 2, 32'h0};
        vecs[3]  = '{1'b1, 4'hC, 32'h4,        4'hF, 0, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,        4'h0, 0, 32'h1};
        vecs[5]  = '{1'b0, 4'h4, 32'h0,        4'h0, 0, 32'h2};
        vecs[6]  = '{1'b0, 4'h8, 32'h0,        4'h0, 0, 32'h3};
        vecs[7]  = '{1'b0, 4'hC, 32'h0,        4'h0, 0, 32'h4};
        vecs[8]  = '{1'b1, 4'hC, 32'h12345678, 4'hF, 1, 32'h0};
        vecs[9]  = '{1'b1, 4'hC, 32'hAABBCCDD, 4'h2, 2, 32'h0};
        vecs[10] = '{1'b0, 4'hC, 32'h0,        4'h0, 0, 32'h1234CC78};
        vecs[11] = '{1'b1, 4'h0, 32'hFFFFFFFC, 4'hF, 0, 32'h0};
        vecs[12] = '{1'b0, 4'h0, 32'h0,        4'h0, 0, 32'hFFFFFFFC};

        rst_n   = 1'b0;
        awaddr  = '0; awprot = '0; awvalid = 1'b0;
        wdata   = '0; wstrb  = '0; wvalid  = 1'b0;
        araddr  = '0; arprot = '0; arvalid = 1'b0;
        bready  = 1'b1;
        rready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(awready), 32'h0);
        chk("rst_wready",  32'(wready),  32'h0);
        chk("rst_arready", 32'(arready), 32'h0);
        chk("rst_bvalid",  32'(bvalid),  32'h0);
        chk("rst_rvalid",  32'(rvalid),  32'h0);
        chk("rst_rdata",   rdata,        32'h0);
        chk("rst_pwm",     32'(pwm_out), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_awready", 32'(awready), 32'h1);
        chk("idle_wready",  32'(wready),  32'h1);
        chk("idle_arready", 32'(arready), 32'h1);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) begin
                b0 = b_cnt;
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].mode);
                repeat (2) @(negedge clk);
                chk($sformatf("vec%0d_bcount", i), 32'(b_cnt - b0), 32'h1);
            end else begin
                axi_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_rdata", i));
            end
        end

        // Write response held off: response and readies must not move
        bready = 1'b0;
        fork
            aw_send(4'hC);
            w_send(32'hCAFE0001, 4'hF);
        join
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bvalid) seen = 1'b1;
            else        @(negedge clk);
        end
        if (!seen) timeout("hold_bvalid");
        for (int i = 0; i < 5; i++) begin
            chk("hold_bvalid",  32'(bvalid),  32'h1);
            chk("hold_awready", 32'(awready), 32'h0);
            chk("hold_wready",  32'(wready),  32'h0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_bvalid",  32'(bvalid),  32'h0);
        chk("release_awready", 32'(awready), 32'h1);

        // Read data held off
        rready = 1'b0;
        ar_send(4'hC);
        for (int i = 0; i < 5; i++) begin
            chk("hold_rvalid",  32'(rvalid),  32'h1);
            chk("hold_rdata",   rdata,        32'hCAFE0001);
            chk("hold_arready", 32'(arready), 32'h0);
            @(negedge clk);
        end
        rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_rvalid",  32'(rvalid),  32'h0);
        chk("release_arready", 32'(arready), 32'h1);

        // Read sampled on the same edge the write lands returns the old value
        fork
            axi_write(4'hC, 32'h00000055, 4'hF, 0);
            begin
                @(negedge clk);
                axi_read(4'hC, 32'hCAFE0001, "rw_same_old");
            end
        join
        axi_read(4'hC, 32'h00000055, "rw_same_new");

        // PWM: period 10 cycles, 3 high
        axi_write(4'h4, 32'd9, 4'hF, 0);
        axi_write(4'h8, 32'd3, 4'hF, 0);
        axi_write(4'h0, 32'd1, 4'hF, 0);
        repeat (25) @(negedge clk);
        count_high(100, c);
        chk("pwm_duty3_highs", 32'(c), 32'd30);

        // DUTY change during a high pulse must wait for the wrap
        l0 = lo_runs.size();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (lo_runs.size() > l0) seen = 1'b1;
            else                     @(negedge clk);
        end
        if (!seen) timeout("pwm_rise");
        h_idx = hi_runs.size();
        l_idx = lo_runs.size();
        axi_write(4'h8, 32'd7, 4'hF, 0);
        repeat (40) @(negedge clk);
        if (hi_runs.size() > h_idx + 1 && lo_runs.size() > l_idx + 1) begin
            chk("shadow_prev_low",  32'(lo_runs[l_idx-1]), 32'd7);
            chk("shadow_cur_high",  32'(hi_runs[h_idx]),   32'd3);
            chk("shadow_cur_low",   32'(lo_runs[l_idx]),   32'd7);
            chk("shadow_new_high",  32'(hi_runs[h_idx+1]), 32'd7);
            chk("shadow_new_low",   32'(lo_runs[l_idx+1]), 32'd3);
        end else begin
            timeout("shadow_runs");
        end

        axi_write(4'h8, 32'd3, 4'hF, 0);
        axi_write(4'h0, 32'd3, 4'hF, 0);
        repeat (30) @(negedge clk);
        count_high(100, c);
        chk("pwm_invert_highs", 32'(c), 32'd70);

        axi_write(4'h0, 32'd2, 4'hF, 0);
        repeat (5) @(negedge clk);
        count_high(20, c);
        chk("pwm_disabled_inv", 32'(c), 32'd20);
        axi_write(4'h0, 32'd0, 4'hF, 0);
        repeat (5) @(negedge clk);
        count_high(20, c);
        chk("pwm_disabled", 32'(c), 32'd0);

        axi_write(4'h8, 32'd0, 4'hF, 0);
        axi_write(4'h0, 32'd1, 4'hF, 0);
        repeat (25) @(negedge clk);
        count_high(50, c);
        chk("pwm_duty0", 32'(c), 32'd0);
        axi_write(4'h8, 32'd20, 4'hF, 0);
        repeat (25) @(negedge clk);
        count_high(50, c);
        chk("pwm_duty_over", 32'(c), 32'd50);
        axi_write(4'h4, 32'd0, 4'hF, 0);
        axi_write(4'h8, 32'd5, 4'hF, 0);
        repeat (25) @(negedge clk);
        count_high(50, c);
        chk("pwm_period0_duty5", 32'(c), 32'd50);
        axi_write(4'h8, 32'd0, 4'hF, 0);
        repeat (25) @(negedge clk);
        count_high(50, c);
        chk("pwm_period0_duty0", 32'(c), 32'd0);

        // Reset in the middle of a write with a read response pending
        axi_write(4'h4, 32'd9, 4'hF, 0);
        axi_write(4'h8, 32'd20, 4'hF, 0);
        repeat (25) @(negedge clk);
        chk("pre_reset_pwm", 32'(pwm_out), 32'h1);
        rready = 1'b0;
        ar_send(4'h8);
        b0 = b_cnt;
        awaddr  = 4'hC; awvalid = 1'b1;
        wdata   = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_awready", 32'(awready), 32'h0);
        chk("mid_rst_wready",  32'(wready),  32'h0);
        chk("mid_rst_arready", 32'(arready), 32'h0);
        chk("mid_rst_bvalid",  32'(bvalid),  32'h0);
        chk("mid_rst_rvalid",  32'(rvalid),  32'h0);
        chk("mid_rst_rdata",   rdata,        32'h0);
        chk("mid_rst_pwm",     32'(pwm_out), 32'h0);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        rready  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        axi_read(4'h8, 32'h0, "post_rst_duty");
        axi_read(4'hC, 32'h0, "post_rst_scratch");
        chk("post_rst_bcount", 32'(b_cnt - b0), 32'h0);
        chk("post_rst_pwm",    32'(pwm_out),    32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
